// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Detects load-use hazards and EX-stage redirects (taken branch or jump), then
// steers the IF/ID instruction select and the PC and ID/EX strobes through the
// stall and bubble cycles. It also counts stall and flush bubbles.
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_ID,
   input  logic [4:0]       rs2_ID,
   input  logic             rs1_used,
   input  logic             rs2_used,
   input  logic [4:0]       rd_EX,
   input  logic             memread_EX,
   input  logic             branch_taken_EX,
   input  logic             jump_EX,
   input  logic             cnt_clr,
   output logic [1:0]       instr_sel,
   output logic             pc_write,
   output logic             pc_redirect,
   output logic             id_ex_flush,
   output logic [CNT_W-1:0] cnt_lu,
   output logic [CNT_W-1:0] cnt_flush
);

   typedef enum logic [1:0] {
      ST_RUN = 2'd0,
      ST_LU  = 2'd1,
      ST_FL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_stateNext;
   logic             w_redirect;
   logic             w_luHit;
   logic             w_incLu;
   logic             w_incFlush;
   logic [CNT_W-1:0] r_cntLu;
   logic [CNT_W-1:0] r_cntFlush;

   // A write to x0 never creates a dependency, and unused sources never stall.
   assign w_redirect = branch_taken_EX | jump_EX;
   assign w_luHit    = memread_EX & (rd_EX != 5'd0) &
                       ((rs1_used & (rs1_ID == rd_EX)) |
                        (rs2_used & (rs2_ID == rd_EX)));

   // Next state and strobes; reset wins, then redirect, then load-use.
   always_comb begin
      w_stateNext = ST_RUN;
      instr_sel   = 2'b00;
      pc_write    = 1'b1;
      pc_redirect = 1'b0;
      id_ex_flush = 1'b0;
      w_incLu     = 1'b0;
      w_incFlush  = 1'b0;
      if (rst) begin
         pc_write    = 1'b0;
         w_stateNext = ST_RUN;
      end else if (w_redirect) begin
         instr_sel   = 2'b10;
         pc_redirect = 1'b1;
         id_ex_flush = 1'b1;
         w_incFlush  = 1'b1;
         w_stateNext = ST_FL;
      end else begin
         case (r_state)
            ST_LU: begin
               instr_sel   = 2'b01;
               w_stateNext = ST_RUN;
            end
            ST_FL: begin
               if (w_luHit) begin
                  pc_write    = 1'b0;
                  id_ex_flush = 1'b1;
                  w_incLu     = 1'b1;
                  w_stateNext = ST_LU;
               end else begin
                  w_incFlush  = 1'b1;
                  w_stateNext = ST_RUN;
               end
            end
            default: begin
               if (w_luHit) begin
                  pc_write    = 1'b0;
                  id_ex_flush = 1'b1;
                  w_incLu     = 1'b1;
                  w_stateNext = ST_LU;
               end else begin
                  w_stateNext = ST_RUN;
               end
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Wrapping performance counters; a clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_cntLu    <= '0;
         r_cntFlush <= '0;
      end else begin
         if (w_incLu) begin
            r_cntLu <= r_cntLu + CNT_ONE;
         end
         if (w_incFlush) begin
            r_cntFlush <= r_cntFlush + CNT_ONE;
         end
      end
   end

   assign cnt_lu    = r_cntLu;
   assign cnt_flush = r_cntFlush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl, using narrow counters so
// that wrap-around can be reached quickly.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       bt;
      logic       jp;
      logic       clr;
      logic       rst;
   } stim_t;

   typedef struct packed {
      logic [1:0]       sel;
      logic             pcw;
      logic             pcr;
      logic             fl;
      logic [CNT_W-1:0] lu;
      logic [CNT_W-1:0] fc;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [4:0]       rs1_ID;
   logic [4:0]       rs2_ID;
   logic             rs1_used;
   logic             rs2_used;
   logic [4:0]       rd_EX;
   logic             memread_EX;
   logic             branch_taken_EX;
   logic             jump_EX;
   logic             cnt_clr;
   logic [1:0]       instr_sel;
   logic             pc_write;
   logic             pc_redirect;
   logic             id_ex_flush;
   logic [CNT_W-1:0] cnt_lu;
   logic [CNT_W-1:0] cnt_flush;

   exp_t expQ[$];
   int   vectors;
   int   miscompares;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .rs1_ID         (rs1_ID),
      .rs2_ID         (rs2_ID),
      .rs1_used       (rs1_used),
      .rs2_used       (rs2_used),
      .rd_EX          (rd_EX),
      .memread_EX     (memread_EX),
      .branch_taken_EX(branch_taken_EX),
      .jump_EX        (jump_EX),
      .cnt_clr        (cnt_clr),
      .instr_sel      (instr_sel),
      .pc_write       (pc_write),
      .pc_redirect    (pc_redirect),
      .id_ex_flush    (id_ex_flush),
      .cnt_lu         (cnt_lu),
      .cnt_flush      (cnt_flush)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic stim_t S(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic bt, input logic jp,
                               input logic clr, input logic r);
      S = {rs1, rs2, u1, u2, rd, mr, bt, jp, clr, r};
   endfunction

   function automatic exp_t E(input logic [1:0] sel, input logic pcw, input logic pcr,
                              input logic fl, input logic [CNT_W-1:0] lu,
                              input logic [CNT_W-1:0] fc);
      E = {sel, pcw, pcr, fl, lu, fc};
   endfunction

   function automatic exp_t observed();
      observed = {instr_sel, pc_write, pc_redirect, id_ex_flush, cnt_lu, cnt_flush};
   endfunction

   task automatic applyStimulus(input stim_t s);
      rs1_ID          = s.rs1;
      rs2_ID          = s.rs2;
      rs1_used        = s.u1;
      rs2_used        = s.u2;
      rd_EX           = s.rd;
      memread_EX      = s.mr;
      branch_taken_EX = s.bt;
      jump_EX         = s.jp;
      cnt_clr         = s.clr;
      rst             = s.rst;
   endtask

   // Reset held two edges with a redirect pending, outputs forced, then release.
   task automatic test_reset();
      stim_t st[4];
      exp_t  ex[4];
      exp_t  got;
      exp_t  want;
      st = '{S(0,0,0,0,0,0,1,0,0,1), S(0,0,0,0,0,0,1,0,0,1),
             S(0,0,0,0,0,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0,0)};
      ex = '{E(2'b00,0,0,0,0,0), E(2'b00,0,0,0,0,0),
             E(2'b00,1,0,0,0,0), E(2'b00,1,0,0,0,0)};
      applyStimulus(S(0,0,0,0,0,0,0,0,0,1));
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         applyStimulus(st[i]);
         expQ.push_back(ex[i]);
         @(negedge clk);
         want = expQ.pop_front();
         got  = observed();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL test_reset[%0d]: got %h required %h", i, got, want);
         end
      end
   endtask

   // Load-use on rs2, held through the replay, then normal flow.
   task automatic test_load_use();
      stim_t st[4];
      exp_t  ex[4];
      exp_t  got;
      exp_t  want;
      st = '{S(0,5,0,1,5,1,0,0,0,0), S(0,5,0,1,5,1,0,0,0,0),
             S(0,0,0,0,0,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0,0)};
      ex = '{E(2'b00,0,0,1,0,0), E(2'b01,1,0,0,1,0),
             E(2'b00,1,0,0,1,0), E(2'b00,1,0,0,1,0)};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         applyStimulus(st[i]);
         expQ.push_back(ex[i]);
         @(negedge clk);
         want = expQ.pop_front();
         got  = observed();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL test_load_use[%0d]: got %h required %h", i, got, want);
         end
      end
   endtask

   // Loads to x0, to unused sources, and non-load matches never stall.
   task automatic test_no_stall();
      stim_t st[4];
      exp_t  ex[4];
      exp_t  got;
      exp_t  want;
      st = '{S(0,0,1,1,0,1,0,0,0,0), S(7,3,0,1,7,1,0,0,0,0),
             S(7,7,1,1,7,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0,0)};
      ex = '{E(2'b00,1,0,0,1,0), E(2'b00,1,0,0,1,0),
             E(2'b00,1,0,0,1,0), E(2'b00,1,0,0,1,0)};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         applyStimulus(st[i]);
         expQ.push_back(ex[i]);
         @(negedge clk);
         want = expQ.pop_front();
         got  = observed();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL test_no_stall[%0d]: got %h required %h", i, got, want);
         end
      end
   endtask

   // Taken branch for one cycle: two bubbles, two flush counts.
   task automatic test_redirect();
      stim_t st[3];
      exp_t  ex[3];
      exp_t  got;
      exp_t  want;
      st = '{S(0,0,0,0,0,0,1,0,0,0), S(0,0,0,0,0,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0,0)};
      ex = '{E(2'b10,1,1,1,1,0), E(2'b00,1,0,0,1,1), E(2'b00,1,0,0,1,2)};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         applyStimulus(st[i]);
         expQ.push_back(ex[i]);
         @(negedge clk);
         want = expQ.pop_front();
         got  = observed();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL test_redirect[%0d]: got %h required %h", i, got, want);
         end
      end
   endtask

   // Redirect beats load-use, jump in FL restarts, load-use in FL stalls.
   task automatic test_priority();
      stim_t st[8];
      exp_t  ex[8];
      exp_t  got;
      exp_t  want;
      st = '{S(0,5,0,1,5,1,1,0,0,0), S(0,0,0,0,0,0,0,1,0,0),
             S(0,0,0,0,0,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0,0),
             S(0,0,0,0,0,0,1,0,0,0), S(9,0,1,0,9,1,0,0,0,0),
             S(9,0,1,0,9,1,0,0,0,0), S(0,0,0,0,0,0,0,0,0,0)};
      ex = '{E(2'b10,1,1,1,1,2), E(2'b10,1,1,1,1,3),
             E(2'b00,1,0,0,1,4), E(2'b00,1,0,0,1,5),
             E(2'b10,1,1,1,1,5), E(2'b00,0,0,1,1,6),
             E(2'b01,1,0,0,2,6), E(2'b00,1,0,0,2,6)};
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         applyStimulus(st[i]);
         expQ.push_back(ex[i]);
         @(negedge clk);
         want = expQ.pop_front();
         got  = observed();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL test_priority[%0d]: got %h required %h", i, got, want);
         end
      end
   endtask

   // Stall immediately followed by a redirect during the replay cycle.
   task automatic test_back_to_back();
      stim_t st[4];
      exp_t  ex[4];
      exp_t  got;
      exp_t  want;
      st = '{S(5,0,1,0,5,1,0,0,0,0), S(0,0,0,0,0,0,1,0,0,0),
             S(0,0,0,0,0,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0,0)};
      ex = '{E(2'b00,0,0,1,2,6), E(2'b10,1,1,1,3,6),
             E(2'b00,1,0,0,3,7), E(2'b00,1,0,0,3,8)};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         applyStimulus(st[i]);
         expQ.push_back(ex[i]);
         @(negedge clk);
         want = expQ.pop_front();
         got  = observed();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL test_back_to_back[%0d]: got %h required %h", i, got, want);
         end
      end
   endtask

   // Reset in LU and in FL returns to RUN with no replay or bubble.
   task automatic test_reset_mid();
      stim_t st[6];
      exp_t  ex[6];
      exp_t  got;
      exp_t  want;
      st = '{S(5,0,1,0,5,1,0,0,0,0), S(5,0,1,0,5,1,0,0,0,1),
             S(0,0,0,0,0,0,0,0,0,0), S(0,0,0,0,0,0,1,0,0,0),
             S(0,0,0,0,0,0,0,0,0,1), S(0,0,0,0,0,0,0,0,0,0)};
      ex = '{E(2'b00,0,0,1,3,8), E(2'b00,0,0,0,4,8),
             E(2'b00,1,0,0,0,0), E(2'b10,1,1,1,0,0),
             E(2'b00,0,0,0,0,1), E(2'b00,1,0,0,0,0)};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         applyStimulus(st[i]);
         expQ.push_back(ex[i]);
         @(negedge clk);
         want = expQ.pop_front();
         got  = observed();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL test_reset_mid[%0d]: got %h required %h", i, got, want);
         end
      end
   endtask

   // Sixteen stalls walk cnt_lu through all-ones and back to zero.
   task automatic test_wrap();
      exp_t got;
      exp_t want;
      for (int k = 0; k < 16; k++) begin
         for (int ph = 0; ph < 2; ph++) begin
            @(posedge clk); #1;
            if (ph == 0) begin
               applyStimulus(S(0,12,0,1,12,1,0,0,0,0));
               expQ.push_back(E(2'b00,0,0,1,CNT_W'(k),0));
            end else begin
               applyStimulus(S(0,0,0,0,0,0,0,0,0,0));
               expQ.push_back(E(2'b01,1,0,0,CNT_W'((k + 1) % 16),0));
            end
            @(negedge clk);
            want = expQ.pop_front();
            got  = observed();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL test_wrap[%0d.%0d]: got %h required %h", k, ph, got, want);
            end
         end
      end
   endtask

   // Clear coincident with a flush increment and with a stall increment.
   task automatic test_clear();
      stim_t st[6];
      exp_t  ex[6];
      exp_t  got;
      exp_t  want;
      st = '{S(0,0,0,0,0,0,1,0,0,0), S(0,0,0,0,0,0,0,0,1,0),
             S(0,0,0,0,0,0,0,0,0,0), S(3,0,1,0,3,1,0,0,1,0),
             S(0,0,0,0,0,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0,0)};
      ex = '{E(2'b10,1,1,1,0,0), E(2'b00,1,0,0,0,1),
             E(2'b00,1,0,0,0,0), E(2'b00,0,0,1,0,0),
             E(2'b01,1,0,0,0,0), E(2'b00,1,0,0,0,0)};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         applyStimulus(st[i]);
         expQ.push_back(ex[i]);
         @(negedge clk);
         want = expQ.pop_front();
         got  = observed();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL test_clear[%0d]: got %h required %h", i, got, want);
         end
      end
   endtask

   // Scenario sequence; counter expectations carry over between tasks.
   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_load_use();
      test_no_stall();
      test_redirect();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      test_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
